// File: rtl/random_generator_if.sv
// ----------------------------------------------------------------------------
// Module      : random_generator_if
// Description : Seed / random-number bundle between the LFSR source and its user.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface random_generator_if;
   logic [15:0] seed;
   logic [15:0] random_number;

   modport master (
      output seed,
      input  random_number
   );

   modport slave (
      input  seed,
      output random_number
   );
endinterface

`default_nettype wire

// File: rtl/random_generator.sv
// ----------------------------------------------------------------------------
// Module      : random_generator
// Description : Free-running 16-bit maximal-length Fibonacci LFSR with seed load.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module random_generator #(
   parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
   input  wire logic          clk,
   input  wire logic          reset,
   random_generator_if.slave  rng
);

   logic [15:0] r_lfsr;
   logic        r_load_pending;
   logic        w_feedback;
   logic [15:0] w_load_value;

   // Taps for x^16 + x^14 + x^13 + x^11 + 1.
   assign w_feedback   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   // All-zero is the LFSR lock-up state, so a zero seed is substituted.
   assign w_load_value = (rng.seed == 16'h0000) ? DEFAULT_SEED : rng.seed;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lfsr         <= 16'h0000;
         r_load_pending <= 1'b1;
      end else if (r_load_pending) begin
         r_lfsr         <= w_load_value;
         r_load_pending <= 1'b0;
      end else begin
         r_lfsr         <= {r_lfsr[14:0], w_feedback};
      end
   end

   assign rng.random_number = r_lfsr;

endmodule

`default_nettype wire

// File: tb/tb_random_generator.sv
// ----------------------------------------------------------------------------
// Module      : tb_random_generator
// Description : Directed self-checking bench for random_generator.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_random_generator;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   random_generator_if rng_if ();

   random_generator dut (
      .clk   (clk),
      .reset (reset),
      .rng   (rng_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and sample just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset(input logic [15:0] s);
      @(negedge clk);
      rng_if.seed = s;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin : stim
      int zero_seen;
      int early_hits;
      logic [15:0] exp_shift;

      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      rng_if.seed  = 16'h1234;

      // Held in reset while the clock runs
      #2;
      check("reset_async", rng_if.random_number, 16'h0000);
      for (int i = 0; i < 3; i++) step();
      check("reset_held", rng_if.random_number, 16'h0000);
      reset = 1'b1;
      check("before_load", rng_if.random_number, 16'h0000);
      step();
      check("load_1234", rng_if.random_number, 16'h1234);

      // Known sequence from ACE1
      apply_reset(16'hACE1);
      step();
      check("load_ace1", rng_if.random_number, 16'hACE1);
      step();
      check("ace1_step1", rng_if.random_number, 16'h59C3);
      step();
      check("ace1_step2", rng_if.random_number, 16'hB387);

      // Single bit walks until it reaches tap 10
      apply_reset(16'h0001);
      step();
      check("load_0001", rng_if.random_number, 16'h0001);
      exp_shift = 16'h0001;
      for (int i = 0; i < 10; i++) begin
         step();
         exp_shift = exp_shift << 1;
         check("walk_0001", rng_if.random_number, exp_shift);
      end
      step();
      check("walk_0801", rng_if.random_number, 16'h0801);

      // Zero seed falls back to the default
      apply_reset(16'h0000);
      step();
      check("zero_seed_default", rng_if.random_number, 16'hACE1);
      step();
      check("zero_seed_step1", rng_if.random_number, 16'h59C3);
      zero_seen = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (rng_if.random_number == 16'h0000) zero_seen++;
      end
      check("zero_seed_no_zero", zero_seen, 0);

      // Full period from ACE1, with a seed change partway through
      apply_reset(16'hACE1);
      step();
      check("period_load", rng_if.random_number, 16'hACE1);
      zero_seen  = 0;
      early_hits = 0;
      for (int i = 1; i < 65535; i++) begin
         step();
         if (i == 2) check("seed_change_before", rng_if.random_number, 16'hB387);
         if (i == 3) rng_if.seed = 16'h5555;
         if (rng_if.random_number == 16'h0000) zero_seen++;
         if (rng_if.random_number == 16'hACE1) early_hits++;
      end
      check("period_no_zero", zero_seen, 0);
      check("period_no_early_repeat", early_hits, 0);
      step();
      check("period_return", rng_if.random_number, 16'hACE1);
      step();
      check("period_wrap_step", rng_if.random_number, 16'h59C3);

      // Mid-run reset between edges
      step();
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("midrun_reset_async", rng_if.random_number, 16'h0000);
      rng_if.seed = 16'hBEEF;
      step();
      check("midrun_reset_held", rng_if.random_number, 16'h0000);
      reset = 1'b1;
      step();
      check("load_beef", rng_if.random_number, 16'hBEEF);
      step();
      check("beef_step1", rng_if.random_number, 16'h7DDE);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
